ws2812_fader: RTL
=================

Name: ws2812_fader

Overview:
- Upstream colour sequencer for the ws2812 core.
- On a start request it cross-fades linearly from colour_a to colour_b in 2^STEPS_LOG2 equal steps.
- Each intermediate colour is presented on rgb_colour/led_mask with a one-cycle write pulse, so it connects directly to the core's rgb_colour, led_mask and write inputs.
- Pacing comes from an internal tick divider, so the core has time to refresh the strip between updates.

Parameters:
- NUM_LEDS, 4, width of led_mask; matches the downstream core.
- STEPS_LOG2, 6, log2 of the number of fade steps (64 by default).
- TICK_DIV, 120000, clk cycles between successive writes; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enable  in  1  1 = tick divider runs; 0 = fade paused, state held.
- start  in  1  single-cycle request to begin a fade; sampled only in IDLE.
- colour_a  in  24  start colour {R,G,B}, 8 bits each; latched on accepted start.
- colour_b  in  24  end colour; latched on accepted start.
- mask_in  in  NUM_LEDS  LED mask; latched on accepted start.
- rgb_colour  out  24  colour for the current step; to the core's rgb_colour.
- led_mask  out  NUM_LEDS  mask for the current step; to the core's led_mask.
- write  out  1  one-cycle strobe marking rgb_colour/led_mask valid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset (reset=0, async): state IDLE, step=0, tick counter=0. rgb_colour=0, led_mask=0, write=0, busy=0, done=0, latched colours=0.
- States: IDLE -> CALC -> EMIT -> WAIT -> (CALC | FINISH) -> IDLE.
- IDLE:
  - start=1 latches colour_a, colour_b and mask_in, clears step, sets busy=1, goes to CALC.
  - start in any other state is ignored.
- CALC (1 cycle): per channel c, diff = b_c - a_c as 9-bit signed.
  - val = a_c + ((diff * step) >>> STEPS_LOG2), using an arithmetic shift (floor).
  - Product width is 10+STEPS_LOG2 bits signed.
  - When step = 2^STEPS_LOG2, val = b_c exactly (forced).
  - The result is registered into rgb_colour; led_mask = latched mask.
- EMIT (1 cycle): write=1. rgb_colour/led_mask are stable in this cycle and hold until the next CALC. Then go to WAIT with the tick counter cleared.
- WAIT:
  - The counter increments only while enable=1.
  - When it reaches TICK_DIV-1 and step < 2^STEPS_LOG2: step++ and go to CALC.
  - When it reaches TICK_DIV-1 and step = 2^STEPS_LOG2: go to FINISH.
- FINISH (1 cycle): done=1, busy=0, then IDLE. rgb_colour holds colour_b.
- Latency:
  - start sampled at edge N gives write high in the cycle after edge N+2; step 0 is colour_a.
  - Writes are spaced TICK_DIV+2 cycles apart while enable stays high.
  - Total writes per fade = 2^STEPS_LOG2 + 1.
- enable=0:
  - Freezes the WAIT counter only; CALC/EMIT/FINISH complete regardless.
  - No write is issued while paused in WAIT.
- colour_a == colour_b: all writes carry the same colour; the sequence still runs in full.
- Boundary: diff = -255 and diff = +255 must not overflow; val always stays within 0..255.
- Reset asserted mid-fade: immediate return to the reset values. No done pulse, and any write in flight is cut.

Optional Feature:
- WS2812_FADER_CHASE_EN defined:
  - On each step increment (WAIT -> CALC), the latched mask rotates left by one, MSB wrapping to bit 0.
  - The mask emitted at step k = mask_in rotated left by k (mod NUM_LEDS).
- Undefined: led_mask = mask_in for every write of the fade.

Test Plan:
- Config for all cases: STEPS_LOG2=2, TICK_DIV=8, NUM_LEDS=4.
- Ascending fade: reset released, start with a=000000, b=FF8040, mask=0101 -> 5 writes with rgb 000000, 3F2010, 7F4020, BF6030, FF8040. Writes are 10 cycles apart, first write 2 cycles after start, done one cycle after the FINISH transition, led_mask=0101 each time.
- Descending fade: a=FF8040, b=000000 -> rgb FF8040, BF6030, 7F4020, 3F2010, 000000 (floor rounding checked).
- Pause and ignored start:
  - Drop enable for 20 cycles after the 2nd write -> 3rd write delayed by exactly 20 cycles; values unchanged.
  - Pulse start while busy -> ignored; latched colours unchanged.
- Reset mid-fade: assert reset after the 3rd write -> all outputs 0 asynchronously, no done; a new start then fades from step 0.
- WS2812_FADER_CHASE_EN, mask_in=0001 -> write masks 0001, 0010, 0100, 1000, 0001; without the macro, all five are 0001.

Source files
------------

// File: rtl/ws2812_fader.sv
// ws2812_fader: linear cross-fade sequencer feeding the ws2812 core.
// Steps from colour_a to colour_b in 2^STEPS_LOG2 equal steps. Each step is
// one registered rgb_colour/led_mask update with a one-cycle write strobe.
// An internal tick divider paces the writes.
// Optional feature: define WS2812_FADER_CHASE_EN to rotate the LED mask left
// by one position on every step.
module ws2812_fader #(
  parameter int unsigned NUM_LEDS   = 4,
  parameter int unsigned STEPS_LOG2 = 6,
  parameter int unsigned TICK_DIV   = 120000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic [23:0]         colour_a,
  input  logic [23:0]         colour_b,
  input  logic [NUM_LEDS-1:0] mask_in,
  output logic [23:0]         rgb_colour,
  output logic [NUM_LEDS-1:0] led_mask,
  output logic                write,
  output logic                busy,
  output logic                done
);

  localparam int unsigned StepW = STEPS_LOG2 + 1;
  localparam int unsigned ProdW = 10 + STEPS_LOG2;
  localparam int unsigned CntW  = $clog2(TICK_DIV);

  localparam logic [StepW-1:0] StepMax = {1'b1, {STEPS_LOG2{1'b0}}};
  localparam logic [CntW-1:0]  CntLast = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StCalc, StEmit, StWait, StFinish} state_e;

  state_e              state_q;
  logic [StepW-1:0]    step_q;
  logic [CntW-1:0]     cnt_q;
  logic [23:0]         col_a_q;
  logic [23:0]         col_b_q;
  logic [NUM_LEDS-1:0] mask_q;
  logic [23:0]         rgb_q;
  logic [NUM_LEDS-1:0] led_mask_q;
  logic                write_q;
  logic                busy_q;
  logic                done_q;
  logic [23:0]         calc_rgb;

  // One channel: a + floor((b - a) * s / 2^STEPS_LOG2), always within 0..255.
  function automatic logic [7:0] lerp(input logic [7:0] a, input logic [7:0] b,
                                      input logic [StepW-1:0] s);
    logic signed [8:0]       diff;
    logic signed [ProdW-1:0] diff_w;
    logic signed [ProdW-1:0] s_w;
    logic signed [ProdW-1:0] prod;
    logic signed [ProdW-1:0] sum;
    diff   = $signed({1'b0, b}) - $signed({1'b0, a});
    diff_w = ProdW'(diff);
    s_w    = $signed(ProdW'({1'b0, s}));
    prod   = diff_w * s_w;
    // Arithmetic shift floors toward -inf, so descending fades round down too.
    sum    = $signed(ProdW'(a)) + (prod >>> STEPS_LOG2);
    return sum[7:0];
  endfunction

`ifdef WS2812_FADER_CHASE_EN
  function automatic logic [NUM_LEDS-1:0] rotl1(input logic [NUM_LEDS-1:0] m);
    return (m << 1) | (m >> (NUM_LEDS - 1));
  endfunction
`endif

  // Colour for the current step; the final step is forced to colour_b exactly.
  always_comb begin
    calc_rgb = {lerp(col_a_q[23:16], col_b_q[23:16], step_q),
                lerp(col_a_q[15:8],  col_b_q[15:8],  step_q),
                lerp(col_a_q[7:0],   col_b_q[7:0],   step_q)};
    if (step_q == StepMax) begin
      calc_rgb = col_b_q;
    end
  end

  // Fade sequencer with registered outputs; write/done are single-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      step_q     <= '0;
      cnt_q      <= '0;
      col_a_q    <= '0;
      col_b_q    <= '0;
      mask_q     <= '0;
      rgb_q      <= '0;
      led_mask_q <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            col_a_q <= colour_a;
            col_b_q <= colour_b;
            mask_q  <= mask_in;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          rgb_q      <= calc_rgb;
          led_mask_q <= mask_q;
          state_q    <= StEmit;
        end
        StEmit: begin
          write_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // Pausing only freezes this counter; no other state waits on enable.
          if (enable) begin
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
              if (step_q == StepMax) begin
                state_q <= StFinish;
              end else begin
                step_q  <= step_q + StepW'(1);
`ifdef WS2812_FADER_CHASE_EN
                mask_q  <= rotl1(mask_q);
`endif
                state_q <= StCalc;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rgb_colour = rgb_q;
  assign led_mask   = led_mask_q;
  assign write      = write_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
